// File: rtl/riscv_lsu_rmw_if.sv
// riscv_lsu_rmw_if: request/response and word-RAM bus of the LSU; slave = LSU side, master = requester/RAM side
interface riscv_lsu_rmw_if #(parameter int AW = 7);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/riscv_lsu_rmw.sv
// riscv_lsu_rmw: RV32I load/store unit with read-modify-write sub-word stores; ports clk, rst_n (async active-low), bus (slave: req/rsp/mem)
module riscv_lsu_rmw #(
  parameter int AW = 7
) (
  input logic             clk,
  input logic             rst_n,
  riscv_lsu_rmw_if.slave  bus
);
  typedef enum logic {IDLE, MERGE} state_e;
  state_e        state_q, state_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [AW-1:0] addr_q;
  logic [1:0]    off_q;
  logic          half_q;
  logic [15:0]   wd_q;
  logic [31:0]   old_q, merged, ld;
  logic [2:0]    f;
  logic [31:0]   a;
  logic          merge, acc, legal, is_h, is_w, mis, oor, err, sub_st, cap;
  logic [7:0]    b;
  logic [15:0]   h;
  assign f      = bus.req_funct3;
  assign a      = bus.req_addr;
  assign merge  = state_q == MERGE;
  assign acc    = bus.req_valid && !merge;
  assign is_h   = f[1:0] == 2'b01;
  assign is_w   = f[1:0] == 2'b10;
  assign legal  = bus.req_we ? !f[2] && f[1:0] != 2'b11 : f != 3'b011 && f != 3'b110 && f != 3'b111;
  assign mis    = (is_h && a[0]) || (is_w && |a[1:0]);
  assign oor    = |a[31:AW+2];
  assign err    = !legal || mis || oor;
  assign sub_st = bus.req_we && !is_w;
  assign b      = bus.mem_rdata[{a[1:0], 3'b000} +: 8];
  assign h      = bus.mem_rdata[{a[1], 4'b0000} +: 16];
  assign ld     = is_w ? bus.mem_rdata
                : is_h ? {{16{!f[2] && h[15]}}, h}
                :        {{24{!f[2] && b[7]}}, b};
  always_comb begin
    merged = old_q;
    if (half_q) merged[{off_q[1], 4'b0000} +: 16] = wd_q;
    else        merged[{off_q, 3'b000} +: 8]      = wd_q[7:0];
  end
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    cap         = 1'b0;
    if (merge) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
    end else if (acc) begin
      if (err) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
      end else if (sub_st) begin
        state_d = MERGE;
        cap     = 1'b1;
      end else begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = bus.req_we ? '0 : ld;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      off_q       <= '0;
      half_q      <= 1'b0;
      wd_q        <= '0;
      old_q       <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (cap) begin
        addr_q <= a[AW+1:2];
        off_q  <= a[1:0];
        half_q <= is_h;
        wd_q   <= bus.req_wdata[15:0];
        old_q  <= bus.mem_rdata;
      end
    end
  end
  // RAM strobes are gated by rst_n so nothing reaches the RAM while reset is held
  assign bus.req_ready = !merge;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_en    = rst_n && (merge || (acc && !err));
  assign bus.mem_we    = rst_n && (merge || (acc && !err && bus.req_we && is_w));
  assign bus.mem_addr  = merge ? addr_q : a[AW+1:2];
  assign bus.mem_wdata = merge ? merged : bus.req_wdata;
endmodule

// File: tb/tb_riscv_lsu_rmw.sv
// tb_riscv_lsu_rmw: scoreboard bench for riscv_lsu_rmw with a word RAM model
module tb_riscv_lsu_rmw;
  localparam int AW = 7;
  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_wait;
  logic last_en, last_we;
  logic [AW-1:0] last_addr;
  logic [31:0] ram [1 << AW];
  exp_t sb [$];
  riscv_lsu_rmw_if #(.AW(AW)) bus ();
  riscv_lsu_rmw #(.AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = ram[bus.mem_addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (sb.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rd);
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err, input int lat);
    int n = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    #1;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) chk("accept_timeout", 32'd1, 32'd0);
    last_wait = n;
    last_en   = bus.mem_en;
    last_we   = bus.mem_we;
    last_addr = bus.mem_addr;
    sb.push_back('{rd: exp_rd, err: exp_err, cyc: cyc + lat});
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    foreach (ram[i]) ram[i] = '0;
    ram[8] = 32'hCAFEF00D;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    rst_n = 1'b1;
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    chk("sw_mem_en", {31'd0, last_en}, 32'd1);
    chk("sw_mem_we", {31'd0, last_we}, 32'd1);
    chk("sw_mem_addr", {25'd0, last_addr}, 32'd4);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);
    chk("lw_mem_we", {31'd0, last_we}, 32'd0);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 1);
    chk("lb_wait", last_wait, 0);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, 1);
    chk("lbu_wait", last_wait, 0);
    issue(1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, 1);
    chk("lh_wait", last_wait, 0);
    issue(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 1);
    chk("lhu_wait", last_wait, 0);
    issue(1'b1, 3'b000, 32'h11, 32'h00000055, 32'h0, 1'b0, 2);
    chk("sb_read_we", {31'd0, last_we}, 32'd0);
    chk("sb_merge_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("sb_merge_en", {31'd0, bus.mem_en}, 32'd1);
    chk("sb_merge_we", {31'd0, bus.mem_we}, 32'd1);
    chk("sb_merge_addr", {25'd0, bus.mem_addr}, 32'd4);
    chk("sb_merge_wdata", bus.mem_wdata, 32'hDEAD55EF);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 1);
    chk("sb_hold_wait", last_wait, 1);
    issue(1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0, 1'b0, 2);
    chk("sh_merge_wdata", bus.mem_wdata, 32'h123455EF);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0, 1);
    chk("sh_hold_wait", last_wait, 1);
    chk("sh_ram", ram[4], 32'h123455EF);
    issue(1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 1'b1, 1);
    chk("err_lw_mis_en", {31'd0, last_en}, 32'd0);
    issue(1'b0, 3'b001, 32'h05, 32'h0, 32'h0, 1'b1, 1);
    chk("err_lh_mis_en", {31'd0, last_en}, 32'd0);
    issue(1'b1, 3'b010, 32'h200, 32'hBAD0BAD0, 32'h0, 1'b1, 1);
    chk("err_sw_oor_en", {31'd0, last_en}, 32'd0);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    chk("err_ld_f3_en", {31'd0, last_en}, 32'd0);
    issue(1'b1, 3'b100, 32'h10, 32'hBAD0BAD0, 32'h0, 1'b1, 1);
    chk("err_st_f3_en", {31'd0, last_en}, 32'd0);
    @(negedge clk);
    chk("err_ram0", ram[0], 32'h0);
    chk("err_ram4", ram[4], 32'h123455EF);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h00000077;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("rstm_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rstm_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rstm_req_ready", {31'd0, bus.req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rstm_ram8", ram[8], 32'hCAFEF00D);
    chk("rstm_ready_after", {31'd0, bus.req_ready}, 32'd1);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/riscv_lsu_rmw.md
Name: riscv_lsu_rmw

Overview:
- Load/store unit in the MEM stage of the 3-stage core. It sits directly upstream of the word-wide data RAM and drives its en/we/addr/wdata port.
- Handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.
- Sub-word stores use a two-cycle read-modify-write, because the RAM has no byte enables.
- Sign/zero-extends load data, flags misaligned, out-of-range and illegal requests, and returns one registered response per accepted request.

Parameters:
AW, 7, RAM word-address width; RAM depth = 2^AW words; valid byte addresses are 0 .. 2^(AW+2)-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; request accepted when req_valid && req_ready
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 of the load/store
req_addr  in  32  byte address
req_wdata  in  32  store data (low byte/half used for SB/SH)
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  valid with rsp_valid: misaligned, out-of-range or illegal funct3
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  AW  RAM word address
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM combinational read data

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, captured registers=0.
- Reset outputs: req_ready=1 whenever state=IDLE. mem_en=0 and mem_we=0 while reset is asserted.
- States: IDLE, MERGE.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Alignment: LH/LHU/SH need addr[0]=0. LW/SW need addr[1:0]=00.
- Range: addr[31:AW+2] must be 0.
- Error request (accepted in IDLE, fails any check above):
  - mem_en=0.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - State stays IDLE.
- Load (IDLE, accepted, legal):
  - Same cycle: mem_en=1, mem_we=0, mem_addr=req_addr[AW+1:2].
  - Byte lane selected by addr[1:0]; half lane selected by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Extended value is registered: rsp_valid=1, rsp_rdata=value, rsp_err=0 on the next cycle.
  - Latency 1. Back-to-back loads run every cycle.
- SW (IDLE, accepted, legal):
  - Same cycle: mem_en=1, mem_we=1, mem_addr=word address, mem_wdata=req_wdata.
  - Next cycle: rsp_valid=1, rsp_rdata=0, rsp_err=0. Latency 1.
- SB/SH (IDLE, accepted, legal):
  - Read cycle: mem_en=1, mem_we=0. Capture mem_rdata, word address, lane offset and store data. Go to MERGE.
  - MERGE cycle:
    - req_ready=0.
    - mem_en=1, mem_we=1, mem_addr=captured address.
    - mem_wdata = captured old word with only the target byte/half replaced; other bytes unchanged.
    - Return to IDLE.
  - Response: rsp_valid=1 on the cycle after MERGE. Total latency 2; throughput one sub-word store per 2 cycles.
- Requests presented while in MERGE are not accepted. The requester holds req_* stable until req_ready=1.
- rsp_valid is high for exactly one cycle per accepted request and never without one.
- Response order equals acceptance order.
- mem_en=0 in IDLE with no accepted request.
- Reset asserted during MERGE: state returns to IDLE immediately. The pending RAM write is abandoned (mem_we=0). No response is issued for that request.
- rsp_rdata holds its value between responses. Consumers use it only when rsp_valid=1.

Test Plan:
1. Reset, then SW addr 0x10 data 0xDEADBEEF; next cycle LW 0x10 -> mem_addr=4, mem_we=1 on store; load response rsp_rdata=0xDEADBEEF, rsp_err=0, 1 cycle after acceptance.
2. Word 0x10 = 0xDEADBEEF: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD; issued back-to-back on consecutive cycles, req_ready stays 1, four responses in order.
3. SB 0x11 data 0x00000055 on word 0xDEADBEEF -> req_ready=0 one cycle; MERGE writes 0xDEAD55EF; rsp_valid 2 cycles after accept; LW 0x10 then returns 0xDEAD55EF.
4. SH 0x12 data 0x1234 on word 0xDEAD55EF -> written 0x123455EF. A request held valid during MERGE is accepted only on the following cycle.
5. Errors: LW 0x02 (misaligned), LH 0x05 (misaligned), SW 0x200 with AW=7 (out of range), funct3=011 (illegal) -> each rsp_err=1, rsp_rdata=0, mem_en=0, memory contents unchanged.
6. Assert rst_n=0 during MERGE of SB 0x20 -> no write reaches RAM, no rsp_valid. After release, state=IDLE and req_ready=1; LW 0x20 returns the old word.
